// File: rtl/dvi_tmds_serializer.sv
// rtl/dvi_tmds_serializer.sv - TMDS encoder and 10:2 serializer for one DVI lane
// Two bits per clkx5in cycle, LSB first, into an external DDR output cell.
module dvi_tmds_serializer #(
    parameter bit INVERT = 1'b1
) (
    input  logic       clkx5in,
    input  logic       rst,
    input  logic       en,
    input  logic       pix_de,
    input  logic [7:0] pix_d,
    input  logic [1:0] pix_c,
    output logic       pix_req,
    output logic [1:0] dout,
    output logic       sym_start
);

    localparam logic [9:0] TOKEN_C00 = 10'h354;
    localparam logic [9:0] TOKEN_C01 = 10'h0AB;
    localparam logic [9:0] TOKEN_C10 = 10'h154;
    localparam logic [9:0] TOKEN_C11 = 10'h2AB;
    localparam logic [2:0] PHASE_LAST = 3'd4;

    logic [2:0] phase;
    logic       in_de;
    logic [7:0] in_d;
    logic [1:0] in_c;
    logic [4:0] cnt;
    logic [9:0] sym;
    logic [9:0] shifter;
    logic [1:0] dout_r;

    logic [9:0] sym_next;
    logic [4:0] cnt_next;
    logic [8:0] q_m;
    logic [3:0] n1d;
    logic [3:0] n1q;
    logic [4:0] diff;
    logic [1:0] pair;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'b000, v[i]};
        end
        return c;
    endfunction

    function automatic logic [8:0] transition_min(input logic [7:0] d, input logic use_xnor);
        logic [8:0] q;
        q = 9'd0;
        q[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        end
        q[8] = ~use_xnor;
        return q;
    endfunction

    assign pix_req = (phase == PHASE_LAST) & en & ~rst;

    // cnt and diff are 5b two's complement; sign is bit 4, arithmetic wraps modulo 32
    always_comb begin
        n1d      = popcount8(in_d);
        q_m      = transition_min(in_d, (n1d > 4'd4) || ((n1d == 4'd4) && !in_d[0]));
        n1q      = popcount8(q_m[7:0]);
        diff     = {n1q, 1'b0} - 5'd8;
        sym_next = TOKEN_C00;
        cnt_next = cnt;
        if (!in_de) begin
            cnt_next = 5'd0;
            case (in_c)
                2'b00:   sym_next = TOKEN_C00;
                2'b01:   sym_next = TOKEN_C01;
                2'b10:   sym_next = TOKEN_C10;
                default: sym_next = TOKEN_C11;
            endcase
        end else if ((cnt == 5'd0) || (diff == 5'd0)) begin
            sym_next = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]};
            cnt_next = q_m[8] ? (cnt + diff) : (cnt - diff);
        end else if (cnt[4] == diff[4]) begin
            sym_next = {1'b1, q_m[8], ~q_m[7:0]};
            cnt_next = cnt + {3'b000, q_m[8], 1'b0} - diff;
        end else begin
            sym_next = {1'b0, q_m[8], q_m[7:0]};
            cnt_next = cnt - {3'b000, ~q_m[8], 1'b0} + diff;
        end
    end

    always_comb begin
        pair = 2'b00;
        case (phase)
            3'd0:    pair = shifter[1:0];
            3'd1:    pair = shifter[3:2];
            3'd2:    pair = shifter[5:4];
            3'd3:    pair = shifter[7:6];
            3'd4:    pair = shifter[9:8];
            default: pair = 2'b00;
        endcase
    end

    // Encoding finishes one edge before the shifter reload so the new symbol is ready in time
    always_ff @(posedge clkx5in) begin
        if (rst) begin
            phase     <= 3'd0;
            cnt       <= 5'd0;
            in_de     <= 1'b0;
            in_d      <= 8'd0;
            in_c      <= 2'b00;
            sym       <= TOKEN_C00;
            shifter   <= TOKEN_C00;
            dout_r    <= 2'b00;
            sym_start <= 1'b0;
        end else if (en) begin
            phase     <= (phase == PHASE_LAST) ? 3'd0 : phase + 3'd1;
            dout_r    <= pair;
            sym_start <= (phase == 3'd0);
            if (phase == 3'd3) begin
                sym <= sym_next;
                cnt <= cnt_next;
            end
            if (phase == PHASE_LAST) begin
                in_de   <= pix_de;
                in_d    <= pix_d;
                in_c    <= pix_c;
                shifter <= sym;
            end
        end
    end

    assign dout = dout_r ^ {2{INVERT}};

endmodule
